arb4_rr_ctrl: RTL

//  Round-robin arbiter sharing one resource between 4 requesters.

---
 rtl/arb4_pkg.sv | 35 +++
 rtl/dec2to4_n.sv | 18 +
 rtl/arb4_rr_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/arb4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package arb4_pkg;

    // Width of the granted-index field {B,A}
    localparam int unsigned SelWidth = 2;

    // Decoder outputs while no grant is live
    localparam logic [3:0] YnIdle = 4'b1111;
    localparam logic       GnIdle = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } arb_state_e;

    // First set request bit scanning ptr, ptr+1, ... (mod 4)
    function automatic logic [SelWidth-1:0] rr_pick(input logic [3:0]          req,
                                                    input logic [SelWidth-1:0] ptr);
        logic [SelWidth-1:0] idx;
        logic [SelWidth-1:0] pick;
        logic                found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + SelWidth'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dec2to4_n.sv
// Active-low 2-to-4 decoder with active-low enable, as seen by the downstream resource.
module dec2to4_n
    import arb4_pkg::*;
(
    input  logic                g_n,
    input  logic [SelWidth-1:0] sel,
    output logic [3:0]          y_n
);

    // Pull the selected line low only while the enable is asserted
    always_comb begin
        y_n = YnIdle;
        if (!g_n) begin
            y_n[sel] = 1'b0;
        end
    end

endmodule

// File: rtl/arb4_rr_ctrl.sv
// Round-robin arbiter for 4 requesters driving an active-low select decoder.
// Optional build macro ARB_LOCK_EN adds a LOCK input that suppresses the hold limit.
module arb4_rr_ctrl
    import arb4_pkg::*;
#(
    parameter int unsigned HOLD_MAX   = 15,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [3:0]          done,
`ifdef ARB_LOCK_EN
    input  logic                lock,
`endif
    output logic                g_n,
    output logic [SelWidth-1:0] sel,
    output logic [3:0]          y_n,
    output logic                busy,
    output logic                timeout
);

    localparam int unsigned CntW = $clog2(HOLD_MAX + 1);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(HOLD_MAX - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    arb_state_e          state_q, state_d;
    logic [SelWidth-1:0] ptr_q, ptr_d;
    logic [SelWidth-1:0] sel_q, sel_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [GapW-1:0]     gap_q, gap_d;
    logic                g_n_q, g_n_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;

    logic lock_on;
    logic hold_hit;
    logic rel_owner;
    logic rel_go;

`ifdef ARB_LOCK_EN
    assign lock_on = lock;
`else
    assign lock_on = 1'b0;
`endif

    // Only the current owner's DONE/REQ bits can end its grant
    assign hold_hit  = (cnt_q == CntLast);
    assign rel_owner = done[sel_q] | ~req[sel_q];
    assign rel_go    = (state_q == StGrant) && (rel_owner || (hold_hit && !lock_on));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        unique case (state_q)
            StIdle: begin
                if (req != 4'b0000) begin
                    sel_d   = rr_pick(req, ptr_q);
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (rel_go) begin
                    ptr_d   = sel_q + SelWidth'(1);
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
                end else if (!hold_hit) begin
                    // Saturates at the limit while locked
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered-output next values derived from the next state
    always_comb begin
        g_n_d     = (state_d != StGrant);
        busy_d    = (state_d != StIdle);
        // Timeout only when the hold limit is the sole release cause
        timeout_d = rel_go && hold_hit && !lock_on && !rel_owner;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            g_n_q     <= GnIdle;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            g_n_q     <= g_n_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign g_n     = g_n_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

    dec2to4_n u_dec (
        .g_n (g_n_q),
        .sel (sel_q),
        .y_n (y_n)
    );

endmodule
